usb_uart_arbiter: RTL and testbench
===================================

Name: usb_uart_arbiter

Overview:
- Shares the single UART transmitter between two byte sources.
  - Source A is the status-annunciator screen stream. It is a pull interface: request with inc, data returns with dout/dout_v.
  - Source B is the packet-log byte stream. It is a push interface using valid/ready.
- Log traffic has priority. It is bounded by a burst limit so the status screen keeps refreshing.
- Sits between the annunciator/logger and the UART TX, all in the clk48 domain.

Parameters:
- LOG_BURST, 32: max consecutive log bytes before an eligible annunciator burst must be granted.
- ANN_BURST, 16: annunciator bytes fetched per grant.
- ANN_TIMEOUT, 255: cycles allowed from ann_inc rise to ann_dout_v before the fetch is aborted.
- REFRESH_DIV, 4800: clk48 cycles between annunciator eligibility tokens (100 µs).

Ports:
- clk48  in  1  system clock, 48 MHz.
- rst_n  in  1  asynchronous active-low reset.
- ann_en  in  1  annunciator stream enabled.
- ann_inc  out  1  byte request to annunciator.
- ann_dout  in  8  annunciator byte.
- ann_dout_v  in  1  annunciator byte valid, single-cycle pulse.
- log_data  in  8  log byte.
- log_valid  in  1  log byte available.
- log_ready  out  1  log byte accepted this cycle (valid & ready = transfer).
- tx_data  out  8  byte to UART.
- tx_start  out  1  one-cycle start pulse to UART.
- tx_busy  in  1  UART shifting; rises the cycle after tx_start.
- grant_log  out  1  current/last grant was log (status light).
- ann_err  out  1  sticky: annunciator fetch timed out.

Behaviour:
- Reset (async, rst_n=0): all outputs 0, state IDLE, all counters 0, token 0.
- Refresh timer:
  - Free-running 0..REFRESH_DIV-1.
  - On wrap, set token=1 if ann_en.
  - Token clears when an ANN burst starts.
  - ann_en=0 clears token immediately.
- States: IDLE, ANN_REQ, ANN_REL, LOG_ACC, TX_START, TX_WAIT.
- IDLE, evaluated in order:
  - (a) token and (log_cnt ≥ LOG_BURST or !log_valid): ann_left ← ANN_BURST, log_cnt ← 0, grant_log ← 0, go to ANN_REQ.
  - (b) log_valid: go to LOG_ACC.
  - (c) otherwise stay in IDLE.
  - If !log_valid and no ANN grant is taken, log_cnt ← 0.
- LOG_ACC:
  - log_ready=1 for exactly one cycle.
  - tx_data ← log_data, log_cnt ← log_cnt+1 (saturating at LOG_BURST), grant_log ← 1.
  - Go to TX_START.
  - log_ready is never asserted in any other state.
- ANN_REQ:
  - ann_inc=1, timeout counter increments.
  - On ann_dout_v: tx_data ← ann_dout, drop ann_inc next cycle, go to ANN_REL.
  - If the counter reaches ANN_TIMEOUT with no dout_v: ann_err ← 1, drop ann_inc, ann_left ← 0, go to IDLE.
  - A dout_v arriving in the same cycle as the timeout wins; no error is flagged.
- ANN_REL:
  - ann_inc=0 for ≥1 cycle, which lets the source re-arm.
  - Then go to TX_START.
  - ann_dout_v seen outside ANN_REQ is ignored.
- TX_START:
  - Wait while tx_busy=1.
  - When tx_busy=0: tx_start=1 for one cycle, go to TX_WAIT.
  - tx_data is held stable from load until the TX_WAIT exit.
- TX_WAIT:
  - Ignore tx_busy for the first cycle after tx_start.
  - Then, when tx_busy=0:
    - If the byte was ANN: ann_left ← ann_left−1. If the result ≠0 and ann_en, go to ANN_REQ; else IDLE.
    - If the byte was LOG: go to IDLE.
- Each byte is sent exactly once and never dropped.
- Throughput limit: min 4 cycles/byte plus UART time.
- ann_en falling mid-burst: the current byte completes, then the burst ends.
- log_cnt counts consecutive log bytes. It resets on an ANN grant or on an idle cycle with !log_valid.
- Worst-case log stall is ANN_BURST byte-times, plus fetch latency.
- ann_err clears only on reset.
- Reset mid-transfer: outputs go to 0 at once. The pending byte is discarded, with no tx_start.

Test Plan:
- Log only: ann_en=0, 5 log bytes 0x41..0x45 held valid, UART busy 10 cycles each → 5 tx_start pulses in order, each log_ready one cycle, grant_log=1, ann_inc never high.
- Ann only: ann_en=1, model returns dout_v 1 cycle after inc with bytes 0x30.. → after first token, exactly 16 bytes sent 0x30..0x3F; the next burst only after the next REFRESH_DIV wrap.
- Contention: log_valid held continuously, token pending → exactly 32 log bytes, then 16 ann bytes, then log resumes; log_ready never high during the ann burst.
- Timeout: ann model never answers → ann_inc high 255 cycles then low, ann_err=1, no tx_start for ann; log traffic is still served.
- Busy/handshake: tx_busy held high 100 cycles before a send → tx_start delayed until busy low, tx_data unchanged; a dout_v pulse injected in ANN_REL is ignored, with no duplicate byte.
- Reset: assert rst_n=0 during TX_WAIT → all outputs 0 within the same cycle (async); after release, the first action waits for fresh log_valid or token.

Source files
------------

// File: rtl/usb_uart_arbiter.sv
// Arbitrates the single UART transmitter between the annunciator pull stream and the
// priority log push stream, with a log burst cap and a periodic annunciator refresh token.
module usb_uart_arbiter #(
   parameter int unsigned LOG_BURST   = 32,
   parameter int unsigned ANN_BURST   = 16,
   parameter int unsigned ANN_TIMEOUT = 255,
   parameter int unsigned REFRESH_DIV = 4800
) (
   input  logic       clk48,
   input  logic       rst_n,
   input  logic       ann_en,
   output logic       ann_inc,
   input  logic [7:0] ann_dout,
   input  logic       ann_dout_v,
   input  logic [7:0] log_data,
   input  logic       log_valid,
   output logic       log_ready,
   output logic [7:0] tx_data,
   output logic       tx_start,
   input  logic       tx_busy,
   output logic       grant_log,
   output logic       ann_err
);
   localparam int unsigned RefW = $clog2(REFRESH_DIV);
   localparam int unsigned LogW = $clog2(LOG_BURST + 1);
   localparam int unsigned AnnW = $clog2(ANN_BURST + 1);
   localparam int unsigned ToW  = $clog2(ANN_TIMEOUT + 1);

   localparam logic [RefW-1:0] RefLast  = RefW'(REFRESH_DIV - 1);
   localparam logic [RefW-1:0] RefOne   = RefW'(1);
   localparam logic [LogW-1:0] LogMax   = LogW'(LOG_BURST);
   localparam logic [LogW-1:0] LogOne   = LogW'(1);
   localparam logic [AnnW-1:0] AnnBurst = AnnW'(ANN_BURST);
   localparam logic [AnnW-1:0] AnnOne   = AnnW'(1);
   localparam logic [ToW-1:0]  ToLast   = ToW'(ANN_TIMEOUT - 1);
   localparam logic [ToW-1:0]  ToOne    = ToW'(1);

   localparam logic [2:0] StIdle    = 3'd0;
   localparam logic [2:0] StAnnReq  = 3'd1;
   localparam logic [2:0] StAnnRel  = 3'd2;
   localparam logic [2:0] StLogAcc  = 3'd3;
   localparam logic [2:0] StTxStart = 3'd4;
   localparam logic [2:0] StTxWait  = 3'd5;

   logic [2:0]      state_q, state_d;
   logic [RefW-1:0] ref_cnt_q, ref_cnt_d;
   logic            token_q, token_d;
   logic [LogW-1:0] log_cnt_q, log_cnt_d;
   logic [AnnW-1:0] ann_left_q, ann_left_d;
   logic [ToW-1:0]  to_cnt_q, to_cnt_d;
   logic [7:0]      tx_data_q, tx_data_d;
   logic            grant_log_q, grant_log_d;
   logic            ann_err_q, ann_err_d;
   logic            src_log_q, src_log_d;
   logic            first_q, first_d;
   logic            ann_grant;
   logic [AnnW-1:0] ann_left_dec;

   assign ann_left_dec = ann_left_q - AnnOne;

   always_comb begin
      state_d     = state_q;
      ref_cnt_d   = (ref_cnt_q == RefLast) ? '0 : ref_cnt_q + RefOne;
      token_d     = token_q;
      log_cnt_d   = log_cnt_q;
      ann_left_d  = ann_left_q;
      to_cnt_d    = to_cnt_q;
      tx_data_d   = tx_data_q;
      grant_log_d = grant_log_q;
      ann_err_d   = ann_err_q;
      src_log_d   = src_log_q;
      first_d     = first_q;
      ann_grant   = 1'b0;
      ann_inc     = 1'b0;
      log_ready   = 1'b0;
      tx_start    = 1'b0;

      unique case (state_q)
         StIdle: begin
            if (token_q && ann_en && ((log_cnt_q >= LogMax) || !log_valid)) begin
               ann_grant   = 1'b1;
               ann_left_d  = AnnBurst;
               log_cnt_d   = '0;
               grant_log_d = 1'b0;
               to_cnt_d    = '0;
               state_d     = StAnnReq;
            end else if (log_valid) begin
               state_d = StLogAcc;
            end else begin
               log_cnt_d = '0;
            end
         end
         StAnnReq: begin
            ann_inc = 1'b1;
            // A byte arriving on the final timeout cycle still wins.
            if (ann_dout_v) begin
               tx_data_d = ann_dout;
               src_log_d = 1'b0;
               state_d   = StAnnRel;
            end else if (to_cnt_q == ToLast) begin
               ann_err_d  = 1'b1;
               ann_left_d = '0;
               state_d    = StIdle;
            end else begin
               to_cnt_d = to_cnt_q + ToOne;
            end
         end
         StAnnRel: state_d = StTxStart;
         StLogAcc: begin
            log_ready   = 1'b1;
            tx_data_d   = log_data;
            grant_log_d = 1'b1;
            src_log_d   = 1'b1;
            if (log_cnt_q < LogMax) log_cnt_d = log_cnt_q + LogOne;
            state_d = StTxStart;
         end
         StTxStart: begin
            if (!tx_busy) begin
               tx_start = 1'b1;
               first_d  = 1'b1;
               state_d  = StTxWait;
            end
         end
         StTxWait: begin
            // tx_busy only rises the cycle after tx_start, so skip that first cycle.
            if (first_q) begin
               first_d = 1'b0;
            end else if (!tx_busy) begin
               if (src_log_q) begin
                  state_d = StIdle;
               end else begin
                  ann_left_d = ann_left_dec;
                  if ((ann_left_dec != '0) && ann_en) begin
                     to_cnt_d = '0;
                     state_d  = StAnnReq;
                  end else begin
                     state_d = StIdle;
                  end
               end
            end
         end
         default: state_d = StIdle;
      endcase

      if (ann_grant) token_d = 1'b0;
      if ((ref_cnt_q == RefLast) && ann_en) token_d = 1'b1;
      if (!ann_en) token_d = 1'b0;
   end

   always_ff @(posedge clk48 or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= StIdle;
         ref_cnt_q   <= '0;
         token_q     <= 1'b0;
         log_cnt_q   <= '0;
         ann_left_q  <= '0;
         to_cnt_q    <= '0;
         tx_data_q   <= 8'h00;
         grant_log_q <= 1'b0;
         ann_err_q   <= 1'b0;
         src_log_q   <= 1'b0;
         first_q     <= 1'b0;
      end else begin
         state_q     <= state_d;
         ref_cnt_q   <= ref_cnt_d;
         token_q     <= token_d;
         log_cnt_q   <= log_cnt_d;
         ann_left_q  <= ann_left_d;
         to_cnt_q    <= to_cnt_d;
         tx_data_q   <= tx_data_d;
         grant_log_q <= grant_log_d;
         ann_err_q   <= ann_err_d;
         src_log_q   <= src_log_d;
         first_q     <= first_d;
      end
   end

   assign tx_data   = tx_data_q;
   assign grant_log = grant_log_q;
   assign ann_err   = ann_err_q;

endmodule

// File: tb/tb_usb_uart_arbiter.sv
// Bench for usb_uart_arbiter: behavioural UART, log source and annunciator models; every
// byte reaching the UART is logged and compared against the sequence the arbitration rules imply.
module tb_usb_uart_arbiter;
   localparam int RefreshDiv = 4800;

   logic clk48;
   logic rst_n, ann_en, ann_inc, ann_dout_v, log_valid, log_ready, tx_start, tx_busy;
   logic grant_log, ann_err;
   logic [7:0] ann_dout, log_data, tx_data;

   int total, bad;

   // Scenario controls (written by the test tasks only).
   logic log_on, busy_hold, ann_answer, inject;
   int busy_fixed, ann_lat_max, log_wr;
   logic [7:0] log_mem [0:255];

   // Observations (written by the environment process only).
   int cyc, log_rd, sent_n, log_acc_n, ready_bad_n, start_busy_n;
   int ann_hi_n, ann_fall_n, ann_last_run, inj_n;
   logic [7:0] sent_data [0:255];
   logic       sent_log  [0:255];
   int         sent_cyc  [0:255];
   int         sent_acc  [0:255];

   usb_uart_arbiter dut (
      .clk48      (clk48),
      .rst_n      (rst_n),
      .ann_en     (ann_en),
      .ann_inc    (ann_inc),
      .ann_dout   (ann_dout),
      .ann_dout_v (ann_dout_v),
      .log_data   (log_data),
      .log_valid  (log_valid),
      .log_ready  (log_ready),
      .tx_data    (tx_data),
      .tx_start   (tx_start),
      .tx_busy    (tx_busy),
      .grant_log  (grant_log),
      .ann_err    (ann_err)
   );

   initial begin
      clk48 = 1'b0;
      forever #5 clk48 = ~clk48;
   end

   // Environment: samples DUT outputs on the falling edge, drives inputs 1 ns after the rising edge.
   initial begin : env
      logic start_seen, acc_seen, rise_seen, lr_prev, ann_prev, inj_pending;
      int busy_left, resp_cd, run;
      logic [7:0] ann_next;
      tx_busy = 0; log_valid = 0; log_data = 0; ann_dout = 0; ann_dout_v = 0;
      lr_prev = 0; ann_prev = 0; inj_pending = 0; busy_left = 0; resp_cd = 0; run = 0;
      ann_next = 8'h30;
      cyc = 0; sent_n = 0; log_acc_n = 0; log_rd = 0; ready_bad_n = 0; start_busy_n = 0;
      ann_hi_n = 0; ann_fall_n = 0; ann_last_run = 0; inj_n = 0;
      forever begin
         @(negedge clk48);
         start_seen = 0; acc_seen = 0; rise_seen = 0;
         if (!rst_n) begin
            cyc = 0; sent_n = 0; log_acc_n = 0; log_rd = 0; ready_bad_n = 0; start_busy_n = 0;
            ann_hi_n = 0; ann_fall_n = 0; ann_last_run = 0; inj_n = 0;
            lr_prev = 0; ann_prev = 0; inj_pending = 0; busy_left = 0; resp_cd = 0; run = 0;
            ann_next = 8'h30;
         end else begin
            cyc++;
            if (tx_start) begin
               if (tx_busy) start_busy_n++;
               if (sent_n < 256) begin
                  sent_data[sent_n] = tx_data;
                  sent_log[sent_n]  = grant_log;
                  sent_cyc[sent_n]  = cyc;
                  sent_acc[sent_n]  = log_acc_n;
                  sent_n++;
               end
               start_seen = 1;
            end
            if (log_ready && (!log_valid || lr_prev)) ready_bad_n++;
            if (log_ready && log_valid) begin
               acc_seen = 1;
               log_acc_n++;
            end
            lr_prev = log_ready;
            if (ann_inc) begin
               ann_hi_n++;
               run++;
               if (!ann_prev) rise_seen = 1;
            end else if (ann_prev) begin
               ann_last_run = run;
               run = 0;
               ann_fall_n++;
            end
            ann_prev = ann_inc;
         end
         @(posedge clk48);
         #1;
         if (!rst_n) begin
            tx_busy = 0; log_valid = 0; ann_dout_v = 0;
         end else begin
            if (acc_seen) log_rd++;
            log_valid = log_on && (log_rd < log_wr);
            log_data  = log_valid ? log_mem[log_rd] : 8'h00;
            if (start_seen) busy_left = (busy_fixed > 0) ? busy_fixed : int'($urandom_range(12, 1));
            tx_busy = busy_hold || (busy_left > 0);
            if (busy_left > 0) busy_left--;
            ann_dout_v = 0;
            if (rise_seen && ann_answer) resp_cd = int'($urandom_range(ann_lat_max, 1));
            if (resp_cd > 0) begin
               resp_cd--;
               if (resp_cd == 0) begin
                  ann_dout_v = 1;
                  ann_dout = ann_next;
                  ann_next++;
                  inj_pending = inject;
               end
            end else if (inj_pending) begin
               // Spurious pulse lands while the arbiter is in its release cycle.
               ann_dout_v = 1;
               ann_dout = 8'hEE;
               inj_pending = 0;
               inj_n++;
            end
         end
      end
   end

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk48);
         #2;
      end
   endtask

   task automatic do_reset();
      log_on = 0; busy_hold = 0; ann_answer = 0; inject = 0; busy_fixed = 0; ann_en = 0;
      ann_lat_max = 1;
      @(posedge clk48);
      #3 rst_n = 0;
      log_wr = 0;
      tick(3);
      rst_n = 1;
      tick(1);
   endtask

   task automatic push_log(input logic [7:0] b);
      log_mem[log_wr] = b;
      log_wr++;
   endtask

   task automatic wait_sent(input int n, input int budget, output logic ok);
      ok = 0;
      for (int i = 0; i < budget; i++) begin
         if (sent_n >= n) begin
            ok = 1;
            break;
         end
         tick(1);
      end
   endtask

   task automatic test_reset();
      rst_n = 0; ann_en = 0; log_on = 0; busy_hold = 0; ann_answer = 0; inject = 0;
      busy_fixed = 0; ann_lat_max = 1; log_wr = 0;
      tick(2);
      total++; if (ann_inc !== 1'b0) begin bad++; $display("FAIL reset_ann_inc got=%b want=0", ann_inc); end
      total++; if (log_ready !== 1'b0) begin bad++; $display("FAIL reset_log_ready got=%b want=0", log_ready); end
      total++; if (tx_start !== 1'b0) begin bad++; $display("FAIL reset_tx_start got=%b want=0", tx_start); end
      total++; if (tx_data !== 8'h00) begin bad++; $display("FAIL reset_tx_data got=%h want=00", tx_data); end
      total++; if (grant_log !== 1'b0) begin bad++; $display("FAIL reset_grant_log got=%b want=0", grant_log); end
      total++; if (ann_err !== 1'b0) begin bad++; $display("FAIL reset_ann_err got=%b want=0", ann_err); end
      rst_n = 1;
      tick(30);
      total++; if (sent_n != 0) begin bad++; $display("FAIL reset_idle_sent got=%0d want=0", sent_n); end
      total++; if (log_acc_n != 0) begin bad++; $display("FAIL reset_idle_ready got=%0d want=0", log_acc_n); end
   endtask

   task automatic test_log_only();
      logic ok;
      logic [7:0] exp_b;
      do_reset();
      busy_fixed = 10;
      for (int i = 0; i < 5; i++) push_log(8'h41 + 8'(i));
      log_on = 1;
      wait_sent(5, 1000, ok);
      total++; if (!ok) begin bad++; $display("FAIL log_only_count got=%0d want=5", sent_n); end
      for (int i = 0; i < 5; i++) begin
         exp_b = 8'h41 + 8'(i);
         total++; if (sent_data[i] !== exp_b) begin bad++; $display("FAIL log_only_byte[%0d] got=%h want=%h", i, sent_data[i], exp_b); end
         total++; if (sent_log[i] !== 1'b1) begin bad++; $display("FAIL log_only_grant[%0d] got=%b want=1", i, sent_log[i]); end
      end
      tick(20);
      total++; if (log_acc_n != 5) begin bad++; $display("FAIL log_only_ready_pulses got=%0d want=5", log_acc_n); end
      // Random bytes with random UART busy times.
      busy_fixed = 0;
      for (int i = 0; i < 8; i++) push_log(8'($urandom));
      wait_sent(13, 2000, ok);
      total++; if (!ok) begin bad++; $display("FAIL log_rand_count got=%0d want=13", sent_n); end
      for (int i = 5; i < 13; i++) begin
         total++; if (sent_data[i] !== log_mem[i]) begin bad++; $display("FAIL log_rand_byte[%0d] got=%h want=%h", i, sent_data[i], log_mem[i]); end
         total++; if (sent_cyc[i] - sent_cyc[i-1] < 4) begin bad++; $display("FAIL log_rand_gap[%0d] got=%0d want>=4", i, sent_cyc[i] - sent_cyc[i-1]); end
      end
      total++; if (ready_bad_n != 0) begin bad++; $display("FAIL log_only_ready_shape got=%0d want=0", ready_bad_n); end
      total++; if (start_busy_n != 0) begin bad++; $display("FAIL log_only_start_busy got=%0d want=0", start_busy_n); end
      total++; if (ann_hi_n != 0) begin bad++; $display("FAIL log_only_ann_inc got=%0d want=0", ann_hi_n); end
   endtask

   task automatic test_ann_only();
      logic ok;
      logic [7:0] exp_b;
      do_reset();
      ann_en = 1; ann_answer = 1; ann_lat_max = 1;
      wait_sent(16, RefreshDiv + 1500, ok);
      total++; if (!ok) begin bad++; $display("FAIL ann_only_count got=%0d want=16", sent_n); end
      total++; if (sent_cyc[0] <= RefreshDiv) begin bad++; $display("FAIL ann_only_first_time got=%0d want>%0d", sent_cyc[0], RefreshDiv); end
      for (int i = 0; i < 16; i++) begin
         exp_b = 8'h30 + 8'(i);
         total++; if (sent_data[i] !== exp_b) begin bad++; $display("FAIL ann_only_byte[%0d] got=%h want=%h", i, sent_data[i], exp_b); end
         total++; if (sent_log[i] !== 1'b0) begin bad++; $display("FAIL ann_only_grant[%0d] got=%b want=0", i, sent_log[i]); end
      end
      for (int i = 0; i < 3 * RefreshDiv; i++) begin
         if (cyc >= 2 * RefreshDiv - 10) break;
         tick(1);
      end
      total++; if (sent_n != 16) begin bad++; $display("FAIL ann_only_no_early_burst got=%0d want=16", sent_n); end
      ann_lat_max = 3;
      wait_sent(17, 400, ok);
      total++; if (!ok) begin bad++; $display("FAIL ann_only_second_burst got=%0d want=17", sent_n); end
      total++; if (sent_cyc[16] <= 2 * RefreshDiv) begin bad++; $display("FAIL ann_only_second_time got=%0d want>%0d", sent_cyc[16], 2 * RefreshDiv); end
      total++; if (sent_data[16] !== 8'h40) begin bad++; $display("FAIL ann_only_second_byte got=%h want=40", sent_data[16]); end
      // Disable mid-burst: current byte completes, burst ends there.
      ann_en = 0;
      tick(300);
      total++; if (sent_n != 17) begin bad++; $display("FAIL ann_only_en_drop got=%0d want=17", sent_n); end
   endtask

   task automatic test_contention();
      logic ok;
      logic [7:0] exp_b;
      do_reset();
      ann_en = 1; ann_answer = 1; ann_lat_max = 3; busy_hold = 1;
      for (int i = 0; i < 60; i++) push_log(8'($urandom));
      log_on = 1;
      tick(RefreshDiv + 100);
      total++; if (sent_n != 0) begin bad++; $display("FAIL cont_stall_sent got=%0d want=0", sent_n); end
      busy_hold = 0;
      wait_sent(49, 4000, ok);
      total++; if (!ok) begin bad++; $display("FAIL cont_count got=%0d want=49", sent_n); end
      for (int i = 0; i < 32; i++) begin
         total++; if (sent_data[i] !== log_mem[i] || sent_log[i] !== 1'b1) begin bad++; $display("FAIL cont_log[%0d] got=%h/%b want=%h/1", i, sent_data[i], sent_log[i], log_mem[i]); end
      end
      for (int i = 32; i < 48; i++) begin
         exp_b = 8'h30 + 8'(i - 32);
         total++; if (sent_data[i] !== exp_b || sent_log[i] !== 1'b0) begin bad++; $display("FAIL cont_ann[%0d] got=%h/%b want=%h/0", i, sent_data[i], sent_log[i], exp_b); end
      end
      total++; if (sent_acc[47] != 32) begin bad++; $display("FAIL cont_ready_in_ann got=%0d want=32", sent_acc[47]); end
      total++; if (sent_data[48] !== log_mem[32] || sent_log[48] !== 1'b1) begin bad++; $display("FAIL cont_resume got=%h/%b want=%h/1", sent_data[48], sent_log[48], log_mem[32]); end
      total++; if (start_busy_n != 0) begin bad++; $display("FAIL cont_start_busy got=%0d want=0", start_busy_n); end
   endtask

   task automatic test_busy_handshake();
      logic ok;
      logic [7:0] exp_b;
      int hold_bad, rel_cyc;
      do_reset();
      busy_hold = 1;
      push_log(8'h5A);
      log_on = 1;
      tick(5);
      hold_bad = 0;
      for (int i = 0; i < 100; i++) begin
         if (tx_start !== 1'b0 || tx_data !== 8'h5A) hold_bad++;
         tick(1);
      end
      total++; if (hold_bad != 0) begin bad++; $display("FAIL busy_hold_cycles got=%0d want=0", hold_bad); end
      rel_cyc = cyc;
      busy_hold = 0;
      wait_sent(1, 50, ok);
      total++; if (!ok || sent_data[0] !== 8'h5A) begin bad++; $display("FAIL busy_release_byte got=%h want=5a", sent_data[0]); end
      total++; if (sent_cyc[0] < rel_cyc) begin bad++; $display("FAIL busy_release_time got=%0d want>=%0d", sent_cyc[0], rel_cyc); end
      ann_en = 1; ann_answer = 1; inject = 1; ann_lat_max = 1;
      wait_sent(17, RefreshDiv + 1500, ok);
      total++; if (!ok) begin bad++; $display("FAIL inject_count got=%0d want=17", sent_n); end
      for (int i = 1; i < 17; i++) begin
         exp_b = 8'h30 + 8'(i - 1);
         total++; if (sent_data[i] !== exp_b) begin bad++; $display("FAIL inject_byte[%0d] got=%h want=%h", i, sent_data[i], exp_b); end
      end
      tick(100);
      total++; if (sent_n != 17) begin bad++; $display("FAIL inject_no_dup got=%0d want=17", sent_n); end
      total++; if (inj_n != 16) begin bad++; $display("FAIL inject_pulses got=%0d want=16", inj_n); end
   endtask

   task automatic test_timeout();
      logic ok;
      do_reset();
      ann_en = 1; ann_answer = 0;
      ok = 0;
      for (int i = 0; i < RefreshDiv + 600; i++) begin
         if (ann_fall_n >= 1) begin
            ok = 1;
            break;
         end
         tick(1);
      end
      total++; if (!ok) begin bad++; $display("FAIL timeout_fall got=%0d want=1", ann_fall_n); end
      total++; if (ann_last_run != 255) begin bad++; $display("FAIL timeout_inc_len got=%0d want=255", ann_last_run); end
      total++; if (ann_err !== 1'b1) begin bad++; $display("FAIL timeout_err got=%b want=1", ann_err); end
      total++; if (sent_n != 0) begin bad++; $display("FAIL timeout_no_tx got=%0d want=0", sent_n); end
      for (int i = 0; i < 3; i++) push_log(8'($urandom));
      log_on = 1;
      wait_sent(3, 400, ok);
      total++; if (!ok) begin bad++; $display("FAIL timeout_log_count got=%0d want=3", sent_n); end
      for (int i = 0; i < 3; i++) begin
         total++; if (sent_data[i] !== log_mem[i]) begin bad++; $display("FAIL timeout_log_byte[%0d] got=%h want=%h", i, sent_data[i], log_mem[i]); end
      end
      total++; if (ann_err !== 1'b1) begin bad++; $display("FAIL timeout_err_sticky got=%b want=1", ann_err); end
   endtask

   // Continues from test_timeout without a reset so ann_err and grant_log are set beforehand.
   task automatic test_reset_mid();
      logic ok;
      busy_fixed = 40;
      push_log(8'h99);
      wait_sent(4, 300, ok);
      total++; if (!ok || sent_data[3] !== 8'h99) begin bad++; $display("FAIL mid_pre_byte got=%h want=99", sent_data[3]); end
      tick(3);
      total++; if (grant_log !== 1'b1 || ann_err !== 1'b1) begin bad++; $display("FAIL mid_pre_flags got=%b%b want=11", grant_log, ann_err); end
      #1 rst_n = 0;
      #1;
      total++; if (tx_start !== 1'b0) begin bad++; $display("FAIL mid_tx_start got=%b want=0", tx_start); end
      total++; if (tx_data !== 8'h00) begin bad++; $display("FAIL mid_tx_data got=%h want=00", tx_data); end
      total++; if (log_ready !== 1'b0 || ann_inc !== 1'b0) begin bad++; $display("FAIL mid_handshake got=%b%b want=00", log_ready, ann_inc); end
      total++; if (grant_log !== 1'b0) begin bad++; $display("FAIL mid_grant_log got=%b want=0", grant_log); end
      total++; if (ann_err !== 1'b0) begin bad++; $display("FAIL mid_ann_err got=%b want=0", ann_err); end
      log_on = 0; ann_en = 0; log_wr = 0; busy_fixed = 0;
      tick(3);
      rst_n = 1;
      tick(60);
      total++; if (sent_n != 0 || log_acc_n != 0) begin bad++; $display("FAIL mid_quiet got=%0d/%0d want=0/0", sent_n, log_acc_n); end
      push_log(8'h77);
      log_on = 1;
      wait_sent(1, 100, ok);
      total++; if (!ok || sent_data[0] !== 8'h77) begin bad++; $display("FAIL mid_fresh_byte got=%h want=77", sent_data[0]); end
   endtask

   initial begin
      total = 0;
      bad = 0;
      test_reset();
      test_log_only();
      test_ann_only();
      test_contention();
      test_busy_handshake();
      test_timeout();
      test_reset_mid();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
